// File: rtl/riscv_regfile_pkg.sv
// Shared RV32I register-file definitions. Decode and writeback use the same
// macros, and this file also exposes them as typed package constants.
`ifndef RISCV_DEFINES_SVH
`define RISCV_DEFINES_SVH
`define XLEN 32
`define REG_ADDR_W 5
`define REG_NUM 32
`endif

package riscv_regfile_pkg;
  localparam int XLEN       = `XLEN;
  localparam int REG_ADDR_W = `REG_ADDR_W;
  localparam int REG_NUM    = `REG_NUM;

  // A read port takes live writeback data when it addresses the register being written.
  // x0 never takes it.
  function automatic logic bypass_hit(input logic we,
                                      input logic [REG_ADDR_W-1:0] rd,
                                      input logic [REG_ADDR_W-1:0] rs);
    return we && (rd == rs) && (rs != {REG_ADDR_W{1'b0}});
  endfunction
endpackage

// File: rtl/riscv_regfile_entry.sv
// One architectural register: an XLEN-wide enable flop with an asynchronous
// reset to INIT.
module riscv_regfile_entry
  import riscv_regfile_pkg::*;
#(
  parameter logic [XLEN-1:0] INIT = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  logic [XLEN-1:0] q_r;

  // Load on the selected writeback edge. Reset overrides the load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= INIT;
    end else if (en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/riscv_regfile.sv
// RV32I integer register file: 31 storage entries, hardwired x0, one write port
// and two combinational read ports with write-through bypass.
module riscv_regfile
  import riscv_regfile_pkg::*;
#(
  parameter logic [XLEN-1:0] REGFILE_INIT = 32'h0000_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_regfile_we,
  input  logic [REG_ADDR_W-1:0] i_regfile_rd,
  input  logic [XLEN-1:0]       i_regfile_rd_data,
  input  logic [REG_ADDR_W-1:0] i_regfile_rs1,
  input  logic [REG_ADDR_W-1:0] i_regfile_rs2,
  output logic [XLEN-1:0]       o_regfile_rs1_data,
  output logic [XLEN-1:0]       o_regfile_rs2_data
);

  logic [XLEN-1:0] entry_q_s [REG_NUM];
  logic [XLEN-1:0] rs1_data_s;
  logic [XLEN-1:0] rs2_data_s;

  // x0 has no storage. This constant slot keeps the read index a full 5 bits wide.
  assign entry_q_s[0] = {XLEN{1'b0}};

  genvar gi;
  generate
    for (gi = 1; gi < REG_NUM; gi++) begin : g_entry
      logic wr_en_s;
      assign wr_en_s = i_regfile_we && (i_regfile_rd == REG_ADDR_W'(gi));

      riscv_regfile_entry #(
        .INIT (REGFILE_INIT)
      ) u_entry (
        .clk (i_clk),
        .rst (i_rst),
        .en  (wr_en_s),
        .d   (i_regfile_rd_data),
        .q   (entry_q_s[gi])
      );
    end
  endgenerate

  // Read muxes. The bypass is gated off during reset so only reset contents are visible.
  always_comb begin
    rs1_data_s = {XLEN{1'b0}};
    rs2_data_s = {XLEN{1'b0}};

    if (i_regfile_rs1 == {REG_ADDR_W{1'b0}}) begin
      rs1_data_s = {XLEN{1'b0}};
    end else if (!i_rst && bypass_hit(i_regfile_we, i_regfile_rd, i_regfile_rs1)) begin
      rs1_data_s = i_regfile_rd_data;
    end else begin
      rs1_data_s = entry_q_s[i_regfile_rs1];
    end

    if (i_regfile_rs2 == {REG_ADDR_W{1'b0}}) begin
      rs2_data_s = {XLEN{1'b0}};
    end else if (!i_rst && bypass_hit(i_regfile_we, i_regfile_rd, i_regfile_rs2)) begin
      rs2_data_s = i_regfile_rd_data;
    end else begin
      rs2_data_s = entry_q_s[i_regfile_rs2];
    end
  end

  assign o_regfile_rs1_data = rs1_data_s;
  assign o_regfile_rs2_data = rs2_data_s;

endmodule

// File: tb/tb_riscv_regfile.sv
// Directed and random self-checking bench for riscv_regfile (REGFILE_INIT = 32'h0A0A0A0A).
module tb_riscv_regfile;

  localparam logic [31:0] INIT = 32'h0A0A_0A0A;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  logic [31:0] ref_q [32];
  int n_compared;
  int n_mismatched;

  riscv_regfile #(
    .REGFILE_INIT (INIT)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_regfile_we       (we),
    .i_regfile_rd       (rd),
    .i_regfile_rd_data  (rd_data),
    .i_regfile_rs1      (rs1),
    .i_regfile_rs2      (rs2),
    .o_regfile_rs1_data (rs1_data),
    .o_regfile_rs2_data (rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] rs);
    if (rs == 5'd0) return 32'h0;
    if (we && rd == rs) return rd_data;
    return ref_q[rs];
  endfunction

  task automatic sweep_model(input string tag);
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      #1;
      check_val({tag, "_rs1"}, rs1_data, (i == 0) ? 32'h0 : ref_q[i]);
      check_val({tag, "_rs2"}, rs2_data, (i == 31) ? 32'h0 : ref_q[31 - i]);
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst = 1'b1; we = 1'b0; rd = 5'd0; rd_data = 32'h0; rs1 = 5'd0; rs2 = 5'd0;
    for (int i = 0; i < 32; i++) ref_q[i] = (i == 0) ? 32'h0 : INIT;

    // Reset contents on both ports
    #1;
    sweep_model("reset");

    @(negedge clk);
    rst = 1'b0;
    tick();

    // Write x5 and x31, then read them back
    we = 1'b1; rd = 5'd5; rd_data = 32'hDEAD_BEEF;
    tick();
    rd = 5'd31; rd_data = 32'h1234_5678;
    tick();
    we = 1'b0; rs1 = 5'd5; rs2 = 5'd31;
    #1;
    check_val("wr_x5", rs1_data, 32'hDEAD_BEEF);
    check_val("wr_x31", rs2_data, 32'h1234_5678);
    ref_q[5]  = 32'hDEAD_BEEF;
    ref_q[31] = 32'h1234_5678;
    sweep_model("after_wr");

    // x0 ignores writes, both during the write cycle and after it
    we = 1'b1; rd = 5'd0; rd_data = 32'hFFFF_FFFF; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    check_val("x0_same_rs1", rs1_data, 32'h0);
    check_val("x0_same_rs2", rs2_data, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check_val("x0_next_rs1", rs1_data, 32'h0);
    check_val("x0_next_rs2", rs2_data, 32'h0);

    // Write-through bypass on both ports
    we = 1'b1; rd = 5'd7; rd_data = 32'hCAFE_F00D; rs1 = 5'd7; rs2 = 5'd7;
    #1;
    check_val("byp_rs1", rs1_data, 32'hCAFE_F00D);
    check_val("byp_rs2", rs2_data, 32'hCAFE_F00D);
    tick();
    we = 1'b0;
    #1;
    check_val("byp_stored_rs1", rs1_data, 32'hCAFE_F00D);
    check_val("byp_stored_rs2", rs2_data, 32'hCAFE_F00D);
    ref_q[7] = 32'hCAFE_F00D;
    rd_data = 32'h1111_1111;
    #1;
    check_val("nobyp_we0", rs1_data, 32'hCAFE_F00D);
    we = 1'b1; rd = 5'd7; rd_data = 32'hABCD_0123; rs1 = 5'd7; rs2 = 5'd5;
    #1;
    check_val("byp_one_rs1", rs1_data, 32'hABCD_0123);
    check_val("byp_one_rs2", rs2_data, 32'hDEAD_BEEF);
    we = 1'b0;
    tick();

    // Reset asserted between edges acts at once and blocks a write across an edge
    rst = 1'b1; we = 1'b1; rd = 5'd3; rd_data = 32'h55AA_55AA; rs1 = 5'd3; rs2 = 5'd5;
    #1;
    check_val("rst_async_rs1", rs1_data, INIT);
    check_val("rst_async_rs2", rs2_data, INIT);
    tick();
    check_val("rst_blocks_wr", rs1_data, INIT);
    for (int i = 1; i < 32; i++) ref_q[i] = INIT;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_rel_byp", rs1_data, 32'h55AA_55AA);
    tick();
    we = 1'b0;
    #1;
    check_val("rst_rel_wr", rs1_data, 32'h55AA_55AA);
    ref_q[3] = 32'h55AA_55AA;
    sweep_model("after_rst");

    // Random traffic against the reference array
    for (int c = 0; c < 1000; c++) begin
      we      = 1'($urandom_range(0, 1));
      rd      = 5'($urandom_range(0, 31));
      rd_data = $urandom;
      rs1     = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2     = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      #1;
      check_val("rand_rs1", rs1_data, model_read(rs1));
      check_val("rand_rs2", rs2_data, model_read(rs2));
      tick();
      if (we && rd != 5'd0) ref_q[rd] = rd_data;
    end
    sweep_model("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
